// File: rtl/cpu_pkg.sv
// Shared types and instruction-format constants for the FP instruction sequencer.
// Field positions follow the 59-bit Imem word layout.
package cpu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StWait,
        StWb,
        StHalt,
        StErr
    } seq_state_e;

    localparam int unsigned InstrW = 59;

    localparam logic [1:0] FlagR = 2'b00;
    localparam logic [1:0] FlagI = 2'b01;

    localparam logic [4:0] OpAdd = 5'b00000;
    localparam logic [4:0] OpMul = 5'b00001;

    localparam int unsigned FlagMsb = 58;
    localparam int unsigned FlagLsb = 57;
    localparam int unsigned OpMsb   = 56;
    localparam int unsigned OpLsb   = 52;
    localparam int unsigned RdMsb   = 51;
    localparam int unsigned RdLsb   = 47;
    localparam int unsigned Rs1Msb  = 46;
    localparam int unsigned Rs1Lsb  = 42;
    localparam int unsigned Rs2Msb  = 41;
    localparam int unsigned Rs2Lsb  = 37;
    localparam int unsigned TagMsb  = 36;
    localparam int unsigned TagLsb  = 32;
    localparam int unsigned ImmMsb  = 31;
    localparam int unsigned ImmLsb  = 0;

    function automatic logic is_legal(input logic [1:0] flag, input logic [4:0] op);
        return ((flag == FlagR) || (flag == FlagI)) && ((op == OpAdd) || (op == OpMul));
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Latches the instruction fields at the end of FETCH and flags illegal encodings.
// pc_tag is carried in the word but deliberately not decoded.
module instr_decode
    import cpu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_latch,
    input  logic [InstrW-1:0] i_instr,
    output logic [4:0]        o_op,
    output logic              o_use_imm,
    output logic [4:0]        o_rd,
    output logic [4:0]        o_rs1,
    output logic [4:0]        o_rs2,
    output logic [31:0]       o_imm,
    output logic              o_legal
);

    logic [1:0]  r_flag;
    logic [4:0]  r_op;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [31:0] r_imm;
    logic        w_unused_tag;

    assign w_unused_tag = ^i_instr[TagMsb:TagLsb];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_flag <= '0;
            r_op   <= '0;
            r_rd   <= '0;
            r_rs1  <= '0;
            r_rs2  <= '0;
            r_imm  <= '0;
        end else if (i_latch) begin
            r_flag <= i_instr[FlagMsb:FlagLsb];
            r_op   <= i_instr[OpMsb:OpLsb];
            r_rd   <= i_instr[RdMsb:RdLsb];
            r_rs1  <= i_instr[Rs1Msb:Rs1Lsb];
            r_rs2  <= i_instr[Rs2Msb:Rs2Lsb];
            r_imm  <= i_instr[ImmMsb:ImmLsb];
        end
    end

    assign o_op      = r_op;
    assign o_use_imm = (r_flag == FlagI);
    assign o_rd      = r_rd;
    assign o_rs1     = r_rs1;
    assign o_rs2     = r_rs2;
    assign o_imm     = r_imm;
    assign o_legal   = is_legal(r_flag, r_op);

endmodule

// File: rtl/instr_sequencer.sv
// Sequences one instruction at a time through FETCH/DECODE/EXEC/WAIT/WB, launching the
// FP unit and waiting for its done pulse with a bounded timeout.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned PROG_LEN    = 32,
    parameter int unsigned FPU_TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_run,
    input  logic [InstrW-1:0] i_instr,
    input  logic              i_fpu_done,
    output logic [4:0]        o_program_counter,
    output logic              o_fetch_stage_enable,
    output logic              o_decode_stage_enable,
    output logic              o_execute_stage_enable,
    output logic              o_writeback_stage_enable,
    output logic              o_fpu_start,
    output logic [4:0]        o_fpu_op,
    output logic              o_use_imm,
    output logic [4:0]        o_rd_addr,
    output logic [4:0]        o_rs1_addr,
    output logic [4:0]        o_rs2_addr,
    output logic [31:0]       o_imm_val,
    output logic              o_reg_we,
    output logic              o_halted,
    output logic              o_err
);

    localparam int unsigned     CntW    = $clog2(FPU_TIMEOUT + 1);
    localparam logic [4:0]      LastPc  = 5'(PROG_LEN - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(FPU_TIMEOUT - 1);

    seq_state_e      r_state;
    seq_state_e      w_state_d;
    logic [4:0]      r_pc;
    logic [CntW-1:0] r_wait_cnt;
    logic            r_fetch;
    logic            r_decode;
    logic            r_exec;
    logic            r_wb;
    logic            r_fpu_start;
    logic            r_reg_we;
    logic            r_halted;
    logic            r_err;
    logic            w_legal;

    instr_decode u_decode (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_latch   (r_state == StFetch),
        .i_instr   (i_instr),
        .o_op      (o_fpu_op),
        .o_use_imm (o_use_imm),
        .o_rd      (o_rd_addr),
        .o_rs1     (o_rs1_addr),
        .o_rs2     (o_rs2_addr),
        .o_imm     (o_imm_val),
        .o_legal   (w_legal)
    );

    // run is only looked at in IDLE and WB so an instruction in flight always completes.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:   if (i_run) w_state_d = StFetch;
            StFetch:  w_state_d = StDecode;
            StDecode: w_state_d = w_legal ? StExec : StErr;
            StExec:   w_state_d = StWait;
            StWait: begin
                if (i_fpu_done) begin
                    w_state_d = StWb;
                end else if (r_wait_cnt == CntLast) begin
                    w_state_d = StErr;
                end
            end
            StWb: begin
                if (r_pc == LastPc) begin
                    w_state_d = StHalt;
                end else if (i_run) begin
                    w_state_d = StFetch;
                end else begin
                    w_state_d = StIdle;
                end
            end
            StHalt:   w_state_d = StHalt;
            StErr:    w_state_d = StErr;
            default:  w_state_d = StIdle;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_pc        <= '0;
            r_wait_cnt  <= '0;
            r_fetch     <= 1'b0;
            r_decode    <= 1'b0;
            r_exec      <= 1'b0;
            r_wb        <= 1'b0;
            r_fpu_start <= 1'b0;
            r_reg_we    <= 1'b0;
            r_halted    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_fetch     <= (w_state_d == StFetch);
            r_decode    <= (w_state_d == StDecode);
            r_exec      <= (w_state_d == StExec) || (w_state_d == StWait);
            r_wb        <= (w_state_d == StWb);
            r_fpu_start <= (w_state_d == StExec);
            r_reg_we    <= (w_state_d == StWb);
            r_halted    <= (w_state_d == StHalt);
            r_err       <= (w_state_d == StErr);
            if (r_state == StWait) begin
                r_wait_cnt <= r_wait_cnt + CntW'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if ((r_state == StWb) && (r_pc != LastPc)) begin
                r_pc <= r_pc + 5'd1;
            end
        end
    end

    assign o_program_counter        = r_pc;
    assign o_fetch_stage_enable     = r_fetch;
    assign o_decode_stage_enable    = r_decode;
    assign o_execute_stage_enable   = r_exec;
    assign o_writeback_stage_enable = r_wb;
    assign o_fpu_start              = r_fpu_start;
    assign o_reg_we                 = r_reg_we;
    assign o_halted                 = r_halted;
    assign o_err                    = r_err;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: an Imem array and a delayed-done FPU model drive
// the DUT, and each reg_we pulse is compared against the expectation queued at load time.
module tb_instr_sequencer;

    localparam int unsigned ProgLen = 4;
    localparam int unsigned Timeout = 64;

    typedef struct {
        logic [4:0]  rd;
        logic [4:0]  op;
        logic        use_imm;
        logic [31:0] imm;
        logic [4:0]  pc;
        int          cyc;
        int          exec_len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [58:0] instr;
    logic        fpu_done;
    logic [4:0]  pc;
    logic        fetch, decode, exec, wb;
    logic        fpu_start;
    logic [4:0]  fpu_op;
    logic        use_imm;
    logic [4:0]  rd_addr, rs1_addr, rs2_addr;
    logic [31:0] imm_val;
    logic        reg_we, halted, err;

    logic [58:0] imem [0:31];
    int unsigned dly_tab [0:31];
    logic        fpu_en;
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          exec_run = 0;
    int          last_exec_len = 0;
    int          halt_fetches = 0;

    always #5 clk = ~clk;

    assign instr = imem[pc];

    instr_sequencer #(
        .PROG_LEN    (ProgLen),
        .FPU_TIMEOUT (Timeout)
    ) dut (
        .i_clk                    (clk),
        .i_rst                    (rst),
        .i_run                    (run),
        .i_instr                  (instr),
        .i_fpu_done               (fpu_done),
        .o_program_counter        (pc),
        .o_fetch_stage_enable     (fetch),
        .o_decode_stage_enable    (decode),
        .o_execute_stage_enable   (exec),
        .o_writeback_stage_enable (wb),
        .o_fpu_start              (fpu_start),
        .o_fpu_op                 (fpu_op),
        .o_use_imm                (use_imm),
        .o_rd_addr                (rd_addr),
        .o_rs1_addr               (rs1_addr),
        .o_rs2_addr               (rs2_addr),
        .o_imm_val                (imm_val),
        .o_reg_we                 (reg_we),
        .o_halted                 (halted),
        .o_err                    (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [58:0] mk(input logic [1:0] f, input logic [4:0] op,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [4:0] tag,
                                       input logic [31:0] imm);
        return {f, op, rd, rs1, rs2, tag, imm};
    endfunction

    function automatic logic cond(input int sel);
        case (sel)
            0:       return halted;
            1:       return err;
            2:       return exec && !fpu_start;
            3:       return pc == 5'd3;
            4:       return fetch && (pc == 5'd2);
            5:       return fpu_start;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_cond(input string tag, input int sel, input int max_cyc);
        int   n = 0;
        logic ok = 1'b0;
        while (n < max_cyc && !ok) begin
            @(negedge clk);
            ok = cond(sel);
            n++;
        end
        check(tag, {63'd0, ok}, 64'd1);
    endtask

    task automatic push_exp(input int idx, input logic [4:0] rd, input logic [4:0] op,
                            input logic ui, input logic [31:0] imm);
        exp_t e;
        e.rd = rd;
        e.op = op;
        e.use_imm = ui;
        e.imm = imm;
        e.pc = 5'(idx);
        e.cyc = 4 + int'(dly_tab[idx]);
        e.exec_len = 1 + int'(dly_tab[idx]);
        sb.push_back(e);
    endtask

    // FPU model: done pulses dly_tab[pc] cycles after the start pulse is seen.
    initial begin
        int unsigned cnt = 0;
        logic        pending = 1'b0;
        fpu_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            fpu_done = 1'b0;
            if (rst) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    cnt--;
                    if (cnt == 0) begin
                        fpu_done = fpu_en;
                        pending = 1'b0;
                    end
                end
                if (fpu_start) begin
                    pending = 1'b1;
                    cnt = dly_tab[pc];
                end
            end
        end
    end

    // Output monitor: stage one-hot, cycle position and scoreboard compare on reg_we.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exec) begin
                exec_run++;
            end else if (exec_run > 0) begin
                last_exec_len = exec_run;
                exec_run = 0;
            end
            if (fetch) cyc = 1;
            else cyc++;
            if (halted && fetch) halt_fetches++;
            check("stage_onehot", {63'd0, $countones({fetch, decode, exec, wb}) <= 1}, 64'd1);
            if (reg_we) begin
                if (sb.size() == 0) begin
                    check("unexpected_reg_we", {63'd0, reg_we}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("wb_rd_addr", {59'd0, rd_addr}, {59'd0, e.rd});
                    check("wb_fpu_op", {59'd0, fpu_op}, {59'd0, e.op});
                    check("wb_use_imm", {63'd0, use_imm}, {63'd0, e.use_imm});
                    check("wb_imm_val", {32'd0, imm_val}, {32'd0, e.imm});
                    check("wb_pc", {59'd0, pc}, {59'd0, e.pc});
                    check("wb_enable", {63'd0, wb}, 64'd1);
                    check("wb_cycle_pos", 64'(cyc), 64'(e.cyc));
                    check("exec_len", 64'(last_exec_len), 64'(e.exec_len));
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_pc"}, {59'd0, pc}, 64'd0);
        check({tag, "_strobes"}, {58'd0, fetch, decode, exec, wb, fpu_start, reg_we}, 64'd0);
        check({tag, "_fields"}, {16'd0, fpu_op, use_imm, rd_addr, rs1_addr, rs2_addr},
              64'd0);
        check({tag, "_imm"}, {32'd0, imm_val}, 64'd0);
        check({tag, "_status"}, {62'd0, halted, err}, 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        run = 1'b0;
        fpu_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            imem[i] = '0;
            dly_tab[i] = 1;
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // Program: R-ADD, I-MUL imm=0, R-MUL with slow FPU, I-ADD with a stale pc_tag.
        imem[0] = mk(2'b00, 5'b00000, 5'd3, 5'd1, 5'd2, 5'd0, 32'hDEAD_BEEF);
        imem[1] = mk(2'b01, 5'b00001, 5'd7, 5'd4, 5'd0, 5'd1, 32'h0000_0000);
        imem[2] = mk(2'b00, 5'b00001, 5'd9, 5'd5, 5'd6, 5'd2, 32'hA5A5_0001);
        imem[3] = mk(2'b01, 5'b00000, 5'd31, 5'd0, 5'd0, 5'd17, 32'hFFFF_FFFF);
        dly_tab[2] = 10;
        push_exp(0, 5'd3, 5'b00000, 1'b0, 32'hDEAD_BEEF);
        push_exp(1, 5'd7, 5'b00001, 1'b1, 32'h0000_0000);
        push_exp(2, 5'd9, 5'b00001, 1'b0, 32'hA5A5_0001);
        push_exp(3, 5'd31, 5'b00000, 1'b1, 32'hFFFF_FFFF);

        rst = 1'b0;
        run = 1'b1;
        wait_cond("reach_fetch_pc2", 4, 40);
        run = 1'b0;
        wait_cond("reach_pc3", 3, 60);
        repeat (3) @(negedge clk);
        check("idle_hold_pc", {59'd0, pc}, 64'd3);
        check("idle_no_strobes", {60'd0, fetch, decode, exec, wb}, 64'd0);
        check("rs1_latched", {59'd0, rs1_addr}, 64'd5);
        check("rs2_latched", {59'd0, rs2_addr}, 64'd6);
        run = 1'b1;
        wait_cond("reach_halt", 0, 40);
        check("halt_pc", {59'd0, pc}, 64'd3);
        check("sb_drained", 64'(sb.size()), 64'd0);
        repeat (10) @(negedge clk);
        check("halt_no_fetch", 64'(halt_fetches), 64'd0);
        check("halt_sticky", {63'd0, halted}, 64'd1);

        // Illegal flag 10: error without any writeback.
        rst = 1'b1;
        imem[0] = mk(2'b10, 5'b00000, 5'd3, 5'd1, 5'd2, 5'd0, 32'h1);
        repeat (2) @(negedge clk);
        check("rst_after_halt_pc", {59'd0, pc}, 64'd0);
        check("rst_after_halt_halted", {63'd0, halted}, 64'd0);
        rst = 1'b0;
        wait_cond("err_flag10", 1, 20);
        repeat (5) @(negedge clk);
        check("err_sticky", {63'd0, err}, 64'd1);
        check("err_no_strobes", {60'd0, fetch, decode, exec, wb}, 64'd0);
        check("err_not_halted", {63'd0, halted}, 64'd0);

        // Illegal opcode 00010.
        rst = 1'b1;
        imem[0] = mk(2'b00, 5'b00010, 5'd3, 5'd1, 5'd2, 5'd0, 32'h1);
        repeat (2) @(negedge clk);
        check("rst_clears_err", {63'd0, err}, 64'd0);
        rst = 1'b0;
        wait_cond("err_opcode", 1, 20);

        // FPU timeout: done withheld for the whole WAIT budget.
        rst = 1'b1;
        imem[0] = mk(2'b00, 5'b00001, 5'd3, 5'd1, 5'd2, 5'd0, 32'h1234_5678);
        fpu_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_cond("timeout_start", 5, 10);
        n = 0;
        while (!err && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", 64'(n), 64'(Timeout + 1));

        // Reset in the middle of WAIT.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_cond("reach_wait", 2, 10);
        repeat (5) @(negedge clk);
        check("in_wait_exec", {63'd0, exec}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_in_wait");
        run = 1'b0;
        rst = 1'b0;
        fpu_en = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_rst", {60'd0, fetch, decode, exec, wb}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
